mac_mem_sequencer: RTL and testbench
====================================

Name: mac_mem_sequencer

Overview:
Memory-side engine for the 3x3 matrix MAC datapath. On a start command it fetches matrix A (3 words) and matrix B (3 words) from data memory over a single request/grant port, then presents all six words in parallel to the MAC wrapper. It captures the three result words and writes them back to memory. It also reports busy/done/error to the control pipeline.

Parameters:
WORD_STRIDE, 4, byte increment between consecutive matrix row words
ADDR_W, 32, memory address width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start_i  input  1  command strobe, sampled only in IDLE
mac_op_i  input  mac_op_t  operation select, latched at accepted start
base_a_i  input  ADDR_W  byte address of matrix A row 0
base_b_i  input  ADDR_W  byte address of matrix B row 0
base_c_i  input  ADDR_W  byte address of result row 0
busy_o  output  1  high from accepted start until DONE exits
done_o  output  1  one-cycle pulse at completion
err_o  output  1  one-cycle pulse, start rejected (misaligned base)
mem_req_o  output  1  memory request valid
mem_we_o  output  1  1 = write, 0 = read
mem_addr_o  output  ADDR_W  request address
mem_wdata_o  output  32  write data
mem_gnt_i  input  1  request accepted this cycle
mem_rvalid_i  input  1  read data valid (>=1 cycle after gnt)
mem_rdata_i  input  32  read data
mat_word0_o..mat_word5_o  output  32 each  registered A rows 0-2, B rows 0-2, to MAC wrapper
mac_op_o  output  mac_op_t  latched op to MAC wrapper
res_word0_i..res_word2_i  input  32 each  result rows from MAC wrapper

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; all outputs 0; mat words, latched op/addresses and counters cleared. Reset mid-operation aborts immediately. mem_req_o drops next cycle with no write completion guaranteed.
- States: IDLE, RD_REQ, RD_WAIT, COMPUTE, WR_REQ, DONE. Word counter k is 3 bits.
- IDLE: start_i=1 with base_a/b/c[1:0]==0 -> latch bases and mac_op, k=0, go RD_REQ, busy_o=1. Any base misaligned -> err_o pulse next cycle, stay IDLE. start_i outside IDLE is ignored.
- RD_REQ: mem_req_o=1, mem_we_o=0. mem_addr_o = base_a + k*WORD_STRIDE for k<3, otherwise base_b + (k-3)*WORD_STRIDE. Request and address are held stable until mem_gnt_i, then go RD_WAIT.
- RD_WAIT: mem_req_o=0. On mem_rvalid_i, mem_rdata_i is stored into mat_word[k]. If k==5 go COMPUTE, otherwise k++ and go RD_REQ. Only one read is outstanding. rvalid in any other state is ignored.
- COMPUTE: one cycle. mat words are stable since the last capture, so the MAC combinational result is settled. res_word0..2_i are registered into result buffer, k=0, go WR_REQ.
- WR_REQ: mem_req_o=1, mem_we_o=1, mem_addr_o = base_c + k*WORD_STRIDE, mem_wdata_o = result[k]. Held until mem_gnt_i. On gnt, if k==2 go DONE, otherwise k++ and stay.
- DONE: done_o=1 for exactly one cycle, busy_o=1, then IDLE (busy_o=0). A start_i in DONE is ignored.
- mat_word*_o and mac_op_o hold their values after completion until the next accepted start.
- Address arithmetic is modulo 2^ADDR_W (wrap allowed, no error).
- Zero-wait timing (gnt same cycle as req, rvalid next cycle), start sampled at edge 0:
  - reads occupy cycles 1-12
  - COMPUTE at cycle 13
  - writes at cycles 14-16
  - done_o at cycle 17
  - latency = 17 cycles

Test Plan:
- Zero-wait run: A words at 0x100/0x104/0x108 = 0x00030201, 0x00060504, 0x00090807; B at 0x200.. = identity rows 0x00000001, 0x00000100, 0x00010000; model returns res = 0x00AABBCC, 0x00DDEEFF, 0x00112233 -> read addresses 0x100, 0x104, 0x108, 0x200, 0x204, 0x208 in order; mat_word0..5 match. Writes to 0x300/0x304/0x308 carry the three res values; done_o at cycle 17.
- Grant stalls: hold mem_gnt_i low 3 cycles on every request and delay rvalid 2 cycles -> addr/we/wdata stable while stalled, same data results, latency = 17 + 6*3 + 6*1 + 3*3 = 50.
- Misaligned start: base_b_i=0x202 -> err_o pulse one cycle, no mem_req_o, busy_o stays 0.
- start_i held high throughout a run and a spurious rvalid during RD_REQ and WR_REQ -> exactly one operation; spurious data not captured; one done_o pulse.
- Reset mid-read (rst_n=0 at cycle 6) -> next cycle all outputs 0, state IDLE; a fresh start then completes normally in 17 cycles.
- Wrap: base_c_i=0xFFFFFFFC -> write addresses 0xFFFFFFFC, 0x00000000, 0x00000004.

Source files
------------

// File: rtl/mac_mem_sequencer_if.sv
// mac_mem_sequencer_if: operation type and the single request/grant memory port
// Ports: master drives req/we/addr/wdata and receives gnt/rvalid/rdata; slave is the mirror
package mac_mem_pkg;
    typedef logic [1:0] mac_op_t;
endpackage

interface mac_mem_sequencer_if #(parameter int ADDR_W = 32) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;
    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mac_mem_sequencer.sv
// mac_mem_sequencer: fetches A/B matrix rows, presents them to the MAC, writes the results back
// Ports: clk/rst_n (sync active-low); start_i/mac_op_i/base_*_i command; busy_o/done_o/err_o status;
//        mem memory master port; mat_word*_o/mac_op_o to MAC wrapper; res_word*_i from MAC wrapper
module mac_mem_sequencer
    import mac_mem_pkg::*;
#(
    parameter int WORD_STRIDE = 4,
    parameter int ADDR_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  mac_op_t             mac_op_i,
    input  logic [ADDR_W-1:0]   base_a_i,
    input  logic [ADDR_W-1:0]   base_b_i,
    input  logic [ADDR_W-1:0]   base_c_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    mac_mem_sequencer_if.master mem,
    output logic [31:0]         mat_word0_o,
    output logic [31:0]         mat_word1_o,
    output logic [31:0]         mat_word2_o,
    output logic [31:0]         mat_word3_o,
    output logic [31:0]         mat_word4_o,
    output logic [31:0]         mat_word5_o,
    output mac_op_t             mac_op_o,
    input  logic [31:0]         res_word0_i,
    input  logic [31:0]         res_word1_i,
    input  logic [31:0]         res_word2_i
);
    localparam logic [2:0] IDLE = 3'd0, RD_REQ = 3'd1, RD_WAIT = 3'd2, COMPUTE = 3'd3, WR_REQ = 3'd4, DONE = 3'd5;
    logic [2:0]        state, k;
    logic [ADDR_W-1:0] base_a, base_b, base_c, stride, rd_addr, wr_addr;
    logic [31:0]       mat [6];
    logic [31:0]       res [3];
    logic              err, aligned;
    mac_op_t           op;
    always_comb begin
        stride    = ADDR_W'(WORD_STRIDE);
        // k 0..2 walks A, k 3..5 walks B
        rd_addr   = (k < 3'd3) ? base_a + ADDR_W'(k) * stride : base_b + ADDR_W'(k - 3'd3) * stride;
        wr_addr   = base_c + ADDR_W'(k) * stride;
        aligned   = base_a_i[1:0] == 2'd0 && base_b_i[1:0] == 2'd0 && base_c_i[1:0] == 2'd0;
        busy_o    = state != IDLE;
        done_o    = state == DONE;
        err_o     = err;
        mem.req   = state == RD_REQ || state == WR_REQ;
        mem.we    = state == WR_REQ;
        mem.addr  = state == RD_REQ ? rd_addr : state == WR_REQ ? wr_addr : '0;
        mem.wdata = state == WR_REQ ? res[k[1:0]] : 32'd0;
    end
    assign mat_word0_o = mat[0];
    assign mat_word1_o = mat[1];
    assign mat_word2_o = mat[2];
    assign mat_word3_o = mat[3];
    assign mat_word4_o = mat[4];
    assign mat_word5_o = mat[5];
    assign mac_op_o    = op;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            k      <= 3'd0;
            err    <= 1'b0;
            op     <= '0;
            base_a <= '0;
            base_b <= '0;
            base_c <= '0;
            mat    <= '{default: '0};
            res    <= '{default: '0};
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: if (start_i) begin
                    if (aligned) begin
                        base_a <= base_a_i;
                        base_b <= base_b_i;
                        base_c <= base_c_i;
                        op     <= mac_op_i;
                        k      <= 3'd0;
                        state  <= RD_REQ;
                    end else begin
                        err <= 1'b1;
                    end
                end
                RD_REQ: if (mem.gnt) state <= RD_WAIT;
                RD_WAIT: if (mem.rvalid) begin
                    mat[k] <= mem.rdata;
                    state  <= (k == 3'd5) ? COMPUTE : RD_REQ;
                    k      <= (k == 3'd5) ? k : k + 3'd1;
                end
                // mat words have been stable since the last capture, so the MAC result is settled
                COMPUTE: begin
                    res   <= '{res_word0_i, res_word1_i, res_word2_i};
                    k     <= 3'd0;
                    state <= WR_REQ;
                end
                WR_REQ: if (mem.gnt) begin
                    state <= (k == 3'd2) ? DONE : WR_REQ;
                    k     <= (k == 3'd2) ? k : k + 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_mem_sequencer.sv
// tb_mac_mem_sequencer: randomized and directed checks of the sequencer against a memory/MAC model
module tb_mac_mem_sequencer;
    import mac_mem_pkg::*;
    logic        clk = 0, rst_n = 0, start = 0, fixed = 0, spur = 0, clr = 0;
    mac_op_t     op = '0, op_o;
    logic [31:0] ba = 0, bb = 0, bc = 0;
    logic        busy, done, err;
    logic [31:0] mw [6];
    logic [31:0] rw [3];
    logic [31:0] fres [3] = '{32'h00AABBCC, 32'h00DDEEFF, 32'h00112233};
    int          vec = 0, miss = 0, gw = 0, rd = 1, stall = 0, rcnt = 0, done_cnt = 0, stable_bad = 0, lat = 0, exp_lat = 0;
    logic [31:0] pdata = 0;
    logic [65:0] held = 0;
    logic        prev_stall = 0;
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] raq [$];
    logic [63:0] wq [$];
    logic [31:0] exp_rd [6];
    logic [31:0] exp_mat [6];
    logic [63:0] exp_wr [3];
    mac_op_t     exp_op;

    always #5 clk = ~clk;

    mac_mem_sequencer_if #(.ADDR_W(32)) bus ();

    mac_mem_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .mac_op_i(op),
        .base_a_i(ba), .base_b_i(bb), .base_c_i(bc),
        .busy_o(busy), .done_o(done), .err_o(err), .mem(bus),
        .mat_word0_o(mw[0]), .mat_word1_o(mw[1]), .mat_word2_o(mw[2]),
        .mat_word3_o(mw[3]), .mat_word4_o(mw[4]), .mat_word5_o(mw[5]),
        .mac_op_o(op_o), .res_word0_i(rw[0]), .res_word1_i(rw[1]), .res_word2_i(rw[2])
    );

    function automatic logic [31:0] mix(input logic [31:0] x, input logic [31:0] y);
        return x ^ {y[15:0], y[31:16]};
    endfunction

    function automatic logic [31:0] rdm(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : 32'd0;
    endfunction

    always_comb for (int j = 0; j < 3; j++) rw[j] = fixed ? fres[j] : mix(mw[j], mw[j+3]);

    assign bus.gnt    = bus.req && stall >= gw;
    assign bus.rvalid = rcnt == 1 || (spur && bus.req);
    assign bus.rdata  = rcnt == 1 ? pdata : 32'hDEADBEEF;

    always @(posedge clk) begin
        stall <= (bus.req && !bus.gnt) ? stall + 1 : 0;
        if (bus.req && bus.gnt && !bus.we) begin
            rcnt  <= rd;
            pdata <= rdm(bus.addr);
        end else if (rcnt != 0) rcnt <= rcnt - 1;
        if (bus.req && bus.gnt && bus.we) mem_arr[bus.addr] = bus.wdata;
        if (prev_stall && held !== {bus.req, bus.we, bus.addr, bus.wdata}) stable_bad <= stable_bad + 1;
        prev_stall <= bus.req && !bus.gnt;
        held       <= {bus.req, bus.we, bus.addr, bus.wdata};
        if (clr) begin
            raq.delete();
            wq.delete();
            done_cnt   <= 0;
            stable_bad <= 0;
        end else begin
            if (bus.req && bus.gnt && bus.we) wq.push_back({bus.addr, bus.wdata});
            if (bus.req && bus.gnt && !bus.we) raq.push_back(bus.addr);
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input mac_op_t o, input int g, input int r, input bit sp, input bit hold);
        for (int j = 0; j < 3; j++) begin
            exp_rd[j]   = a + 32'(4 * j);
            exp_rd[j+3] = b + 32'(4 * j);
        end
        for (int j = 0; j < 6; j++) exp_mat[j] = rdm(exp_rd[j]);
        for (int j = 0; j < 3; j++) exp_wr[j] = {c + 32'(4 * j), fixed ? fres[j] : mix(exp_mat[j], exp_mat[j+3])};
        exp_op  = o;
        exp_lat = 17 + 9 * g + 6 * (r - 1);
        @(negedge clk);
        clr = 1; gw = g; rd = r;
        @(negedge clk);
        clr = 0; ba = a; bb = b; bc = c; op = o; start = 1; spur = sp;
        @(negedge clk);
        if (!hold) start = 0;
        lat = 1;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        start = 0; spur = 0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(negedge clk);
        vec++;
        if ({busy, done, err, bus.req, bus.we, bus.addr, bus.wdata, mw[0], mw[1], mw[2], mw[3], mw[4], mw[5], op_o} !== '0) begin
            miss++;
            $display("FAIL reset_outputs got busy=%b done=%b err=%b req=%b addr=%h exp all zero", busy, done, err, bus.req, bus.addr);
        end
        rst_n = 1;
    endtask

    task automatic test_zero_wait;
        logic [31:0] am [6] = '{32'h00030201, 32'h00060504, 32'h00090807, 32'h00000001, 32'h00000100, 32'h00010000};
        for (int j = 0; j < 3; j++) begin
            mem_arr[32'h100 + 32'(4 * j)] = am[j];
            mem_arr[32'h200 + 32'(4 * j)] = am[j+3];
        end
        fixed = 1;
        run_op(32'h100, 32'h200, 32'h300, 2'd1, 0, 1, 0, 0);
        vec++;
        if (lat !== 17) begin miss++; $display("FAIL zw_latency got %0d exp 17", lat); end
        for (int j = 0; j < 6; j++) begin
            vec++;
            if (raq.size() != 6 || raq[j] !== exp_rd[j]) begin miss++; $display("FAIL zw_rd_addr%0d got %h exp %h", j, raq.size() > j ? raq[j] : 32'hX, exp_rd[j]); end
            vec++;
            if (mw[j] !== am[j]) begin miss++; $display("FAIL zw_mat%0d got %h exp %h", j, mw[j], am[j]); end
        end
        for (int j = 0; j < 3; j++) begin
            vec++;
            if (wq.size() != 3 || wq[j] !== {32'h300 + 32'(4 * j), fres[j]}) begin miss++; $display("FAIL zw_write%0d got %h exp %h", j, wq.size() > j ? wq[j] : 64'hX, {32'h300 + 32'(4 * j), fres[j]}); end
        end
        vec++;
        if (op_o !== 2'd1 || busy !== 1'b0 || done_cnt != 1) begin miss++; $display("FAIL zw_status got op=%0d busy=%b dones=%0d exp op=1 busy=0 dones=1", op_o, busy, done_cnt); end
    endtask

    task automatic test_stalls;
        run_op(32'h100, 32'h200, 32'h300, 2'd2, 3, 2, 0, 0);
        vec++;
        if (lat !== 50) begin miss++; $display("FAIL stall_latency got %0d exp 50", lat); end
        vec++;
        if (stable_bad != 0) begin miss++; $display("FAIL stall_stable got %0d unstable cycles exp 0", stable_bad); end
        for (int j = 0; j < 3; j++) begin
            vec++;
            if (wq.size() != 3 || wq[j] !== exp_wr[j]) begin miss++; $display("FAIL stall_write%0d got %h exp %h", j, wq.size() > j ? wq[j] : 64'hX, exp_wr[j]); end
        end
        fixed = 0;
    endtask

    task automatic test_misaligned;
        @(negedge clk);
        clr = 1; gw = 0; rd = 1;
        @(negedge clk);
        clr = 0; ba = 32'h100; bb = 32'h202; bc = 32'h300; start = 1;
        @(negedge clk);
        start = 0;
        vec++;
        if (err !== 1'b1 || busy !== 1'b0) begin miss++; $display("FAIL misalign_err got err=%b busy=%b exp err=1 busy=0", err, busy); end
        @(negedge clk);
        vec++;
        if (err !== 1'b0) begin miss++; $display("FAIL misalign_pulse got err=%b exp 0", err); end
        repeat (3) @(negedge clk);
        vec++;
        if (raq.size() + wq.size() != 0 || busy !== 1'b0) begin miss++; $display("FAIL misalign_noreq got %0d requests busy=%b exp 0 requests busy=0", raq.size() + wq.size(), busy); end
    endtask

    task automatic test_hold_spurious;
        for (int j = 0; j < 6; j++) mem_arr[32'h800 + 32'(4 * j)] = $urandom;
        run_op(32'h800, 32'h80C, 32'h900, 2'd3, 2, 1, 1, 1);
        vec++;
        if (done_cnt != 1 || raq.size() != 6 || wq.size() != 3) begin miss++; $display("FAIL hold_single_op got dones=%0d reads=%0d writes=%0d exp 1/6/3", done_cnt, raq.size(), wq.size()); end
        for (int j = 0; j < 6; j++) begin
            vec++;
            if (mw[j] !== exp_mat[j]) begin miss++; $display("FAIL spur_mat%0d got %h exp %h", j, mw[j], exp_mat[j]); end
        end
        repeat (3) @(negedge clk);
        vec++;
        if (busy !== 1'b0 || lat !== exp_lat) begin miss++; $display("FAIL hold_idle got busy=%b lat=%0d exp busy=0 lat=%0d", busy, lat, exp_lat); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        gw = 0; rd = 1; ba = 32'h100; bb = 32'h200; bc = 32'h300; op = 2'd2; start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        vec++;
        if ({busy, done, err, bus.req, bus.we, bus.addr, bus.wdata, mw[0], mw[1], mw[2], mw[3], mw[4], mw[5], op_o} !== '0) begin
            miss++;
            $display("FAIL reset_mid_outputs got busy=%b req=%b addr=%h mat0=%h op=%0d exp all zero", busy, bus.req, bus.addr, mw[0], op_o);
        end
        rst_n = 1;
        run_op(32'h100, 32'h200, 32'h300, 2'd1, 0, 1, 0, 0);
        vec++;
        if (lat !== 17 || wq.size() != 3 || wq[2] !== exp_wr[2]) begin miss++; $display("FAIL reset_mid_rerun got lat=%0d writes=%0d exp lat=17 writes=3", lat, wq.size()); end
    endtask

    task automatic test_wrap;
        logic [31:0] ea [3] = '{32'hFFFFFFFC, 32'h00000000, 32'h00000004};
        run_op(32'h400, 32'h500, 32'hFFFFFFFC, 2'd0, 1, 1, 0, 0);
        for (int j = 0; j < 3; j++) begin
            vec++;
            if (wq.size() != 3 || wq[j][63:32] !== ea[j]) begin miss++; $display("FAIL wrap_addr%0d got %h exp %h", j, wq.size() > j ? wq[j][63:32] : 32'hX, ea[j]); end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, c;
        for (int n = 0; n < 8; n++) begin
            a = $urandom & 32'hFFFFFFFC;
            b = $urandom & 32'hFFFFFFFC;
            c = $urandom & 32'hFFFFFFFC;
            for (int j = 0; j < 3; j++) begin
                mem_arr[a + 32'(4 * j)] = $urandom;
                mem_arr[b + 32'(4 * j)] = $urandom;
            end
            run_op(a, b, c, mac_op_t'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(1, 3), 0, 0);
            vec++;
            if (lat !== exp_lat) begin miss++; $display("FAIL rnd%0d_latency got %0d exp %0d", n, lat, exp_lat); end
            vec++;
            if (op_o !== exp_op || done_cnt != 1 || stable_bad != 0) begin miss++; $display("FAIL rnd%0d_status got op=%0d dones=%0d unstable=%0d exp op=%0d 1 0", n, op_o, done_cnt, stable_bad, exp_op); end
            for (int j = 0; j < 6; j++) begin
                vec++;
                if (raq.size() != 6 || raq[j] !== exp_rd[j]) begin miss++; $display("FAIL rnd%0d_rd_addr%0d got %h exp %h", n, j, raq.size() > j ? raq[j] : 32'hX, exp_rd[j]); end
                vec++;
                if (mw[j] !== exp_mat[j]) begin miss++; $display("FAIL rnd%0d_mat%0d got %h exp %h", n, j, mw[j], exp_mat[j]); end
            end
            for (int j = 0; j < 3; j++) begin
                vec++;
                if (wq.size() != 3 || wq[j] !== exp_wr[j]) begin miss++; $display("FAIL rnd%0d_write%0d got %h exp %h", n, j, wq.size() > j ? wq[j] : 64'hX, exp_wr[j]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stalls();
        test_misaligned();
        test_hold_spurious();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
